// File: rtl/detect_pkg.sv
// Shared definitions for the droplet detector.
//   det_state_t     : FSM state encoding (also exported on stateoutput)
//   DS_*_LSB        : bit offsets of the fields inside the 128-bit object record
//   is_read_state() : states in which words are pulled from the source FIFO
package detect_pkg;

  typedef enum logic [1:0] {
    BG_ACC  = 2'd0,
    BG_DIV  = 2'd1,
    OUT_OBJ = 2'd2,
    IN_OBJ  = 2'd3
  } det_state_t;

  localparam int DS_FIELD_W   = 32;
  localparam int DS_START_LSB = 96;
  localparam int DS_COUNT_LSB = 64;
  localparam int DS_PEAK_LSB  = 32;

  function automatic logic is_read_state(input det_state_t s);
    return s != BG_DIV;
  endfunction

endpackage

// File: rtl/pix_absdiff_sum.sv
// Per-word arithmetic: |pix - bg| for every pixel lane and the sum of all lanes.
// Purely combinational.
//   pix  : incoming word, PIX_PER_WORD lanes of PIX_W bits
//   bg   : background word, same layout
//   diff : per-lane absolute difference
//   sum  : sum of all lanes of diff
module pix_absdiff_sum #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 16
) (
  input  logic [PIX_W*PIX_PER_WORD-1:0] pix,
  input  logic [PIX_W*PIX_PER_WORD-1:0] bg,
  output logic [PIX_W*PIX_PER_WORD-1:0] diff,
  output logic [31:0]                   sum
);

  logic [PIX_W-1:0] a;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] d;

  always_comb begin
    diff = '0;
    sum  = '0;
    a    = '0;
    b    = '0;
    d    = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      a = pix[i*PIX_W +: PIX_W];
      b = bg[i*PIX_W +: PIX_W];
      d = (a >= b) ? (a - b) : (b - a);
      diff[i*PIX_W +: PIX_W] = d;
      sum = sum + 32'(d);
    end
  end

endmodule

// File: rtl/droplet_detect.sv
// Droplet detector: learns a per-column background from the first BG_LINES
// scan lines, then streams background-subtracted lines and reports objects
// (runs of lines whose summed difference exceeds thr).
//   clk, reset (async, active low)
//   rddata/rdempty/rdfifo : source FIFO (data valid the cycle after rdfifo)
//   thr                   : line-sum threshold
//   wrfull                : sink FIFO full
//   writedata/detectdata  : noise-removed word strobe + data
//   writesize/detectsize  : object record strobe + {start, count, peak, 0}
//   stateoutput, periodcounteroutput, linecounteroutput : debug mirrors
//
// state   | meaning
// BG_ACC  | accumulating background lines into per-column sums
// BG_DIV  | dividing the sums down to averages, one word per cycle
// OUT_OBJ | streaming, waiting for ENTER_CNT consecutive above lines
// IN_OBJ  | inside an object, writing words out until EXIT_CNT quiet lines
module droplet_detect
  import detect_pkg::*;
#(
  parameter int PIX_W          = 8,
  parameter int PIX_PER_WORD   = 16,
  parameter int WORDS_PER_LINE = 21,
  parameter int BG_LINES       = 8,
  parameter int ENTER_CNT      = 3,
  parameter int EXIT_CNT       = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W*PIX_PER_WORD-1:0] rddata,
  input  logic                          rdempty,
  output logic                          rdfifo,
  input  logic [31:0]                   thr,
  input  logic                          wrfull,
  output logic                          writedata,
  output logic [PIX_W*PIX_PER_WORD-1:0] detectdata,
  output logic                          writesize,
  output logic [127:0]                  detectsize,
  output logic [4:0]                    stateoutput,
  output logic [7:0]                    periodcounteroutput,
  output logic [15:0]                   linecounteroutput
);

  localparam int WORD_W = PIX_W*PIX_PER_WORD;
  localparam int SHIFT  = $clog2(BG_LINES);
  localparam int ACC_W  = PIX_W + SHIFT;
  localparam int WC_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int NPIX   = WORDS_PER_LINE*PIX_PER_WORD;
  localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [WC_W-1:0] WC_LAST    = WC_W'(WORDS_PER_LINE-1);
  localparam logic [15:0]     BG_LAST    = 16'(BG_LINES-1);
  localparam logic [7:0]      ENTER_LAST = 8'(ENTER_CNT-1);
  localparam logic [7:0]      EXIT_LAST  = 8'(EXIT_CNT-1);

  det_state_t state_q, state_d;

  logic              rd_vld;
  logic [WC_W-1:0]   word_cnt;
  logic [15:0]       line_cnt;
  logic [31:0]       line_sum;
  logic [7:0]        enter_run, exit_run;
  logic [15:0]       obj_start;
  logic [31:0]       obj_lines, obj_peak;

  logic [ACC_W-1:0]  bg_mem [NPIX];
  logic [IDX_W-1:0]  base_idx;
  logic [WORD_W-1:0] bg_word, diff_word;
  logic [31:0]       word_sum, line_total, peak_now;
  logic              last_word, line_end, above, enter_hit, exit_hit, rd_go;

  assign base_idx = IDX_W'(word_cnt) * IDX_W'(PIX_PER_WORD);

  always_comb begin
    bg_word = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      bg_word[i*PIX_W +: PIX_W] = bg_mem[base_idx + IDX_W'(i)][PIX_W-1:0];
    end
  end

  pix_absdiff_sum #(
    .PIX_W       (PIX_W),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_absdiff (
    .pix (rddata),
    .bg  (bg_word),
    .diff(diff_word),
    .sum (word_sum)
  );

  assign last_word  = (word_cnt == WC_LAST);
  assign line_total = line_sum + word_sum;
  assign above      = (line_total > thr);
  assign line_end   = rd_vld && last_word && (state_q == OUT_OBJ || state_q == IN_OBJ);
  assign enter_hit  = line_end && (state_q == OUT_OBJ) && above && (enter_run == ENTER_LAST);
  assign exit_hit   = line_end && (state_q == IN_OBJ) && !above && (exit_run == EXIT_LAST);
  assign peak_now   = (line_total > obj_peak) ? line_total : obj_peak;

  // Only one word in flight at a time, so a state change on a line's last
  // word always governs the next word fetched.
  assign rd_go = !rdfifo && !rd_vld && !rdempty && !wrfull && is_read_state(state_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BG_ACC:  if (rd_vld && last_word && line_cnt == BG_LAST) state_d = BG_DIV;
      BG_DIV:  if (last_word) state_d = OUT_OBJ;
      OUT_OBJ: if (enter_hit) state_d = IN_OBJ;
      IN_OBJ:  if (exit_hit) state_d = OUT_OBJ;
      default: state_d = BG_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BG_ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdfifo     <= 1'b0;
      rd_vld     <= 1'b0;
      writedata  <= 1'b0;
      writesize  <= 1'b0;
      detectdata <= '0;
      detectsize <= '0;
      word_cnt   <= '0;
      line_cnt   <= '0;
      line_sum   <= '0;
      enter_run  <= '0;
      exit_run   <= '0;
      obj_start  <= '0;
      obj_lines  <= '0;
      obj_peak   <= '0;
    end else begin
      rdfifo    <= rd_go;
      rd_vld    <= rdfifo;
      writedata <= 1'b0;
      writesize <= 1'b0;

      if (state_q == BG_DIV || rd_vld) word_cnt <= last_word ? '0 : word_cnt + 1'b1;

      unique case (state_q)
        BG_ACC:  if (rd_vld && last_word) line_cnt <= (state_d == BG_DIV) ? '0 : line_cnt + 1'b1;
        BG_DIV:  line_cnt <= '0;
        default: if (line_end && line_cnt != 16'hFFFF) line_cnt <= line_cnt + 1'b1;
      endcase

      if (rd_vld && (state_q == OUT_OBJ || state_q == IN_OBJ))
        line_sum <= last_word ? '0 : line_total;

      if (line_end) begin
        if (state_q == OUT_OBJ) begin
          enter_run <= (above && !enter_hit) ? enter_run + 1'b1 : '0;
          exit_run  <= '0;
        end else begin
          exit_run  <= (!above && !exit_hit) ? exit_run + 1'b1 : '0;
          enter_run <= '0;
        end
      end

      if (enter_hit) begin
        obj_start <= (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 1'b1;
        obj_lines <= '0;
        obj_peak  <= '0;
      end else if (line_end && state_q == IN_OBJ) begin
        obj_lines <= obj_lines + 1'b1;
        obj_peak  <= peak_now;
      end

      if (exit_hit) begin
        writesize <= 1'b1;
        detectsize[DS_START_LSB +: DS_FIELD_W] <= {16'd0, obj_start};
        detectsize[DS_COUNT_LSB +: DS_FIELD_W] <= obj_lines + 1'b1;
        detectsize[DS_PEAK_LSB  +: DS_FIELD_W] <= peak_now;
        detectsize[DS_FIELD_W-1:0]             <= '0;
      end

      // In-flight words are written even if wrfull has just risen.
      if (rd_vld && state_q == IN_OBJ) begin
        writedata  <= 1'b1;
        detectdata <= diff_word;
      end
    end
  end

  // Background RAM carries no reset; line 0 of BG_ACC overwrites it.
  always_ff @(posedge clk) begin
    if (rd_vld && state_q == BG_ACC) begin
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        if (line_cnt == '0)
          bg_mem[base_idx + IDX_W'(i)] <= ACC_W'(rddata[i*PIX_W +: PIX_W]);
        else
          bg_mem[base_idx + IDX_W'(i)] <= bg_mem[base_idx + IDX_W'(i)] + ACC_W'(rddata[i*PIX_W +: PIX_W]);
      end
    end else if (state_q == BG_DIV) begin
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        bg_mem[base_idx + IDX_W'(i)] <= bg_mem[base_idx + IDX_W'(i)] >> SHIFT;
      end
    end
  end

  assign stateoutput         = 5'(state_q);
  assign periodcounteroutput = 8'(word_cnt);
  assign linecounteroutput   = line_cnt;

endmodule
